// File: rtl/fabric_mem_store_port.sv
// fabric_mem_store_port: joins address/data streams into a request FIFO and issues one memory write plus one done token per store
module fabric_mem_store_port #(
  parameter int ELEM_WIDTH = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int TAG_WIDTH = 0,
  parameter int MEM_AW = 10,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_PW = ADDR_WIDTH + TAG_WIDTH,
  localparam int ELEM_PW = ELEM_WIDTH + TAG_WIDTH,
  localparam int DONE_PW = TAG_WIDTH > 0 ? TAG_WIDTH : 1,
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in0_valid,
  output logic               in0_ready,
  input  logic [ADDR_PW-1:0] in0_data,
  input  logic               in1_valid,
  output logic               in1_ready,
  input  logic [ELEM_PW-1:0] in1_data,
  output logic               mem_wr_valid,
  input  logic               mem_wr_ready,
  output logic [MEM_AW-1:0]  mem_wr_addr,
  output logic [ELEM_WIDTH-1:0] mem_wr_data,
  output logic               done_valid,
  input  logic               done_ready,
  output logic [DONE_PW-1:0] done_data,
  output logic               err_valid,
  output logic [1:0]         err_code,
  output logic [OCC_W-1:0]   occupancy
);
  localparam int TW = TAG_WIDTH > 0 ? TAG_WIDTH : 1;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;

  if (ELEM_WIDTH < 1 || ADDR_WIDTH < 1 || MEM_AW < 1 || MEM_AW > ADDR_WIDTH || FIFO_DEPTH < 1) begin : g_bad_params
    $fatal(1, "fabric_mem_store_port: illegal parameter combination");
  end

  typedef struct packed {
    logic [MEM_AW-1:0]     addr;
    logic [ELEM_WIDTH-1:0] data;
    logic [TW-1:0]         tag;
    logic                  mis;
    logic                  rng;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  logic [TW-1:0] a_tag, d_tag;

  if (TAG_WIDTH > 0) begin : g_tag
    assign a_tag = in0_data[ADDR_PW-1 -: TAG_WIDTH];
    assign d_tag = in1_data[ELEM_PW-1 -: TAG_WIDTH];
  end else begin : g_notag
    assign a_tag = '0;
    assign d_tag = '0;
  end

  entry_t mem_q [FIFO_DEPTH];
  entry_t mem_d [FIFO_DEPTH];
  entry_t in_e, head;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  state_t st_q, st_d;
  logic err_q, err_d;
  logic [1:0] code_q, code_d;
  logic push, pop, full, flagged;

  assign head = mem_q[rd_q];
  assign flagged = head.mis | head.rng;
  assign full = cnt_q == OCC_W'(FIFO_DEPTH);
  // Ready is gated by rst_n so nothing is taken while reset is held
  assign in0_ready = rst_n && in0_valid && in1_valid && !full;
  assign in1_ready = in0_ready;
  assign push = in0_ready;
  assign mem_wr_valid = st_q == ISSUE && !flagged;
  assign mem_wr_addr = mem_wr_valid ? head.addr : '0;
  assign mem_wr_data = mem_wr_valid ? head.data : '0;
  assign done_valid = st_q == RESP;
  assign done_data = done_valid ? head.tag : '0;
  assign pop = done_valid && done_ready;
  assign err_valid = err_q;
  assign err_code = code_q;
  assign occupancy = cnt_q;

  always_comb begin
    in_e.addr = in0_data[MEM_AW-1:0];
    in_e.data = in1_data[ELEM_WIDTH-1:0];
    in_e.tag = a_tag;
    in_e.mis = a_tag != d_tag;
    in_e.rng = (in0_data[ADDR_WIDTH-1:0] >> MEM_AW) != '0;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = in_e;
    wr_d = push ? (wr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d = pop ? (rd_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
    cnt_d = cnt_q + OCC_W'(push) - OCC_W'(pop);
    err_d = err_q;
    code_d = code_q;
    if (st_q == ISSUE && flagged && !err_q) begin
      err_d = 1'b1;
      code_d = {head.mis, head.rng};
    end
  end

  // Next state looks at cnt_d so an accept reaches ISSUE on the very next cycle
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    st_d = cnt_d != '0 ? ISSUE : IDLE;
      ISSUE:   st_d = flagged || mem_wr_ready ? RESP : ISSUE;
      RESP:    st_d = !pop ? RESP : cnt_d != '0 ? ISSUE : IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      st_q <= IDLE;
      err_q <= 1'b0;
      code_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      st_q <= st_d;
      err_q <= err_d;
      code_q <= code_d;
    end
  end
endmodule

// File: tb/tb_fabric_mem_store_port.sv
// tb_fabric_mem_store_port: directed and random stores checked against a queue-based reference model
module tb_fabric_mem_store_port;
  localparam int AW = 16, TW = 2, EW = 32, MAW = 10, DEPTH = 4;

  logic clk = 0, rst_n = 0;
  logic in0_valid = 0, in1_valid = 0, mem_wr_ready = 1, done_ready = 1;
  logic [AW+TW-1:0] in0_data = '0;
  logic [EW+TW-1:0] in1_data = '0;
  logic in0_ready, in1_ready, mem_wr_valid, done_valid, err_valid;
  logic [MAW-1:0] mem_wr_addr;
  logic [EW-1:0] mem_wr_data;
  logic [TW-1:0] done_data;
  logic [1:0] err_code;
  logic [2:0] occupancy;

  fabric_mem_store_port #(.ELEM_WIDTH(EW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .MEM_AW(MAW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .done_valid(done_valid), .done_ready(done_ready), .done_data(done_data),
    .err_valid(err_valid), .err_code(err_code), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int addr;
    logic [31:0] data;
    int tag;
    bit rng;
    bit mis;
  } ent_t;

  ent_t q[$];
  int checks = 0, errors = 0, n_wr = 0, n_done = 0, wrote = 0;
  bit m_err = 0, acc_last = 0;
  logic [1:0] m_code = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit exp_rdy, wr_hs, dn_hs;
    ent_t e;
    @(negedge clk);
    exp_rdy = rst_n && in0_valid && in1_valid && q.size() < DEPTH;
    chk("in0_ready", in0_ready, exp_rdy);
    chk("in1_ready", in1_ready, exp_rdy);
    chk("occupancy", occupancy, q.size());
    chk("wr_done_exclusive", mem_wr_valid & done_valid, 0);
    if (mem_wr_valid) begin
      chk("wr_with_entry", q.size() > 0, 1);
      if (q.size() > 0) begin
        chk("wr_unflagged", q[0].rng | q[0].mis, 0);
        chk("wr_addr", mem_wr_addr, q[0].addr);
        chk("wr_data", mem_wr_data, q[0].data);
      end
    end
    if (done_valid) begin
      chk("done_with_entry", q.size() > 0, 1);
      if (q.size() > 0) begin
        chk("done_data", done_data, q[0].tag);
        if ((q[0].rng || q[0].mis) && !m_err) begin
          m_err = 1;
          m_code = {q[0].mis, q[0].rng};
        end
      end
    end
    chk("err_valid", err_valid, m_err);
    chk("err_code", err_code, m_code);
    wr_hs = mem_wr_valid && mem_wr_ready;
    dn_hs = done_valid && done_ready;
    e.addr = int'(in0_data[AW-1:0]);
    e.data = in1_data[EW-1:0];
    e.tag = int'(in0_data[AW+TW-1:AW]);
    e.rng = e.addr >= (1 << MAW);
    e.mis = in0_data[AW+TW-1:AW] != in1_data[EW+TW-1:EW];
    @(posedge clk);
    acc_last = exp_rdy;
    if (!rst_n) begin
      q.delete();
      wrote = 0;
      m_err = 0;
      m_code = 0;
    end else begin
      if (wr_hs) begin
        wrote++;
        n_wr++;
      end
      if (dn_hs && q.size() > 0) begin
        chk("writes_per_store", wrote, (q[0].rng || q[0].mis) ? 0 : 1);
        q.pop_front();
        wrote = 0;
        n_done++;
      end
      if (exp_rdy) q.push_back(e);
    end
    #1;
  endtask

  task automatic put(input int at, input int a, input int dt, input logic [31:0] d);
    in0_valid = 1;
    in1_valid = 1;
    in0_data = {2'(at), 16'(a)};
    in1_data = {2'(dt), d};
  endtask

  task automatic idle_inputs();
    in0_valid = 0;
    in1_valid = 0;
  endtask

  task automatic send(input int at, input int a, input int dt, input logic [31:0] d);
    put(at, a, dt, d);
    acc_last = 0;
    for (int i = 0; i < 40 && !acc_last; i++) cyc();
    chk("send_accepted", acc_last, 1);
    idle_inputs();
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && q.size() > 0; i++) cyc();
    chk("drain_empty", q.size(), 0);
    cyc();
  endtask

  task automatic reset_chk();
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    chk("rst_mem_wr_valid", mem_wr_valid, 0);
    chk("rst_mem_wr_addr", mem_wr_addr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_data", done_data, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_occupancy", occupancy, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    put(1, 9, 1, 32'h1234);
    cyc();
    reset_chk();
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    int w0, d0;
    logic [TW-1:0] dd;
    logic [31:0] rd;
    int at;
    rst_n = 0;
    put(0, 1, 0, 32'h55);
    repeat (2) @(posedge clk);
    #1;
    reset_chk();
    rst_n = 1;
    idle_inputs();
    cyc();

    // basic store latency
    mem_wr_ready = 1;
    done_ready = 1;
    put(0, 5, 0, 32'hDEADBEEF);
    cyc();
    chk("basic_accept", acc_last, 1);
    idle_inputs();
    chk("basic_wr_valid", mem_wr_valid, 1);
    chk("basic_wr_addr", mem_wr_addr, 5);
    chk("basic_wr_data", mem_wr_data, 32'hDEADBEEF);
    cyc();
    chk("basic_done_valid", done_valid, 1);
    chk("basic_done_data", done_data, 0);
    cyc();
    chk("basic_after_done", done_valid, 0);
    chk("basic_occ", occupancy, 0);

    // fill and stall
    mem_wr_ready = 0;
    for (int i = 0; i < 4; i++) begin
      put(0, 16 + i, 0, 32'hA0 + i);
      cyc();
    end
    put(0, 20, 0, 32'hA4);
    repeat (3) cyc();
    chk("fill_occ", occupancy, 4);
    chk("fill_ready5", in0_ready, 0);
    mem_wr_ready = 1;
    d0 = n_done;
    acc_last = 0;
    for (int i = 0; i < 30 && !acc_last; i++) cyc();
    chk("fifth_accepted", acc_last, 1);
    chk("fifth_after_first_pop", n_done - d0, 1);
    idle_inputs();
    drain();

    // out of range
    send(0, 'h400, 0, 32'h11);
    drain();
    chk("range_err_valid", err_valid, 1);
    chk("range_err_code", err_code, 2'b01);
    w0 = n_wr;
    send(0, 3, 0, 32'h22);
    drain();
    chk("range_then_write", n_wr - w0, 1);
    chk("range_code_sticky", err_code, 2'b01);

    // tag mismatch
    do_reset();
    w0 = n_wr;
    send(1, 7, 2, 32'h33);
    drain();
    chk("tag_no_write", n_wr - w0, 0);
    chk("tag_err_code", err_code, 2'b10);
    send(3, 8, 3, 32'h44);
    drain();
    chk("tag_match_write", n_wr - w0, 1);
    chk("tag_code_sticky", err_code, 2'b10);

    // done backpressure
    done_ready = 0;
    mem_wr_ready = 1;
    put(0, $urandom_range(0, 1023), 0, $urandom);
    for (int i = 0; i < 10 && !done_valid; i++) begin
      cyc();
      if (acc_last) put(0, $urandom_range(0, 1023), 0, $urandom);
    end
    chk("bp_done_seen", done_valid, 1);
    dd = done_data;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (acc_last) put(0, $urandom_range(0, 1023), 0, $urandom);
      chk("bp_done_held", done_valid, 1);
      chk("bp_done_data_held", done_data, dd);
      chk("bp_no_write", mem_wr_valid, 0);
    end
    chk("bp_fifo_full", occupancy, 4);
    idle_inputs();
    done_ready = 1;
    drain();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      at = $urandom_range(0, 3);
      rd = $urandom;
      in0_valid = $urandom_range(0, 3) != 0;
      in1_valid = $urandom_range(0, 3) != 0;
      in0_data = {2'(at), 16'($urandom_range(0, 1100))};
      in1_data = {($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'(at), rd};
      mem_wr_ready = $urandom_range(0, 2) != 0;
      done_ready = $urandom_range(0, 2) != 0;
      cyc();
    end
    idle_inputs();
    mem_wr_ready = 1;
    done_ready = 1;
    drain();

    // steady throughput
    w0 = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) w0 = n_wr;
      at = $urandom_range(0, 3);
      put(at, $urandom_range(0, 1023), at, $urandom);
      cyc();
    end
    chk("throughput_20cyc", n_wr - w0, 10);
    idle_inputs();
    drain();

    // reset mid-write with entries queued
    mem_wr_ready = 0;
    send(0, 30, 0, 32'h301);
    send(0, 31, 0, 32'h302);
    send(0, 32, 0, 32'h303);
    chk("mid_in_issue", mem_wr_valid, 1);
    chk("mid_occ", occupancy, 3);
    do_reset();
    mem_wr_ready = 1;
    w0 = n_wr;
    d0 = n_done;
    repeat (10) cyc();
    chk("mid_no_stale_write", n_wr - w0, 0);
    chk("mid_no_stale_done", n_done - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
